coffee_brew_ctrl: RTL and testbench

COFFEE_BREW_CTRL -- requirements
Module: coffee_brew_ctrl

---
 rtl/coffee_brew_ctrl.sv | 141 ++++++++++++++
 tb/tb_coffee_brew_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/coffee_brew_ctrl.sv
// coffee_brew_ctrl: Moore FSM sequencing one cup through check, grind, heat,
// pour, optional change dispense and a done pulse, with a latched fault state.
// Every output is decoded from the registered state only. The state code is
// exported on 'state' for debug and checker binding.
module coffee_brew_ctrl #(
  parameter int T_GRIND    = 4,
  parameter int T_HEAT_MAX = 10,
  parameter int T_POUR     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vend_req,
  input  logic       change_req,
  input  logic       cup_present,
  input  logic       water_ok,
  input  logic       heat_ready,
  input  logic       fault_clr,
  output logic       grinder_on,
  output logic       heater_on,
  output logic       pump_on,
  output logic       change_out,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    GRIND  = 3'd2,
    HEAT   = 3'd3,
    POUR   = 3'd4,
    CHANGE = 3'd5,
    DONE   = 3'd6,
    FAULT  = 3'd7
  } state_t;

  // The counter is loaded with duration-1 on phase entry, so a phase lasts
  // exactly 'duration' cycles and exits in the cycle the counter reads zero.
  localparam logic [7:0] GRIND_LD = 8'(T_GRIND - 1);
  localparam logic [7:0] HEAT_LD  = 8'(T_HEAT_MAX - 1);
  localparam logic [7:0] POUR_LD  = 8'(T_POUR - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       chg_pend_q, chg_pend_d;

  // State, phase counter and pending-change flag; reset clears all at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      chg_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      chg_pend_q <= chg_pend_d;
    end
  end

  // Next-state, counter and change-flag logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    chg_pend_d = chg_pend_q;
    case (state_q)
      IDLE: begin
        // vend_req is only looked at here; elsewhere it is simply dropped.
        if (vend_req) begin
          state_d    = CHECK;
          chg_pend_d = change_req;
        end
      end
      CHECK: begin
        if (cup_present && water_ok) begin
          state_d = GRIND;
          cnt_d   = GRIND_LD;
        end else begin
          state_d = FAULT;
        end
      end
      GRIND: begin
        if (cnt_q == 8'd0) begin
          state_d = HEAT;
          cnt_d   = HEAT_LD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HEAT: begin
        if (heat_ready) begin
          state_d = POUR;
          cnt_d   = POUR_LD;
        end else if (cnt_q == 8'd0) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      POUR: begin
        // A missing cup overrides the pour timer.
        if (!cup_present) begin
          state_d = FAULT;
        end else if (cnt_q == 8'd0) begin
          state_d = chg_pend_q ? CHANGE : DONE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      CHANGE: begin
        chg_pend_d = 1'b0;
        state_d    = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        // Pending change is held through the fault and dropped on clear.
        if (fault_clr) begin
          state_d    = IDLE;
          chg_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from the registered state only; one actuator per state.
  assign grinder_on = (state_q == GRIND);
  assign heater_on  = (state_q == HEAT);
  assign pump_on    = (state_q == POUR);
  assign change_out = (state_q == CHANGE);
  assign done       = (state_q == DONE);
  assign fault      = (state_q == FAULT);
  assign busy       = (state_q != IDLE);
  assign state      = state_q;

endmodule

// File: tb/tb_coffee_brew_ctrl.sv
// tb_coffee_brew_ctrl: table-driven vectors for the nominal and pre-check
// flows, plus hand-written sequences for heat timeout, cup removal and
// asynchronous reset mid-pour.
module tb_coffee_brew_ctrl;

  // Expected output patterns {grinder,heater,pump,change,busy,done,fault}.
  localparam logic [6:0] O_IDL = 7'b0000000;
  localparam logic [6:0] O_CHK = 7'b0000100;
  localparam logic [6:0] O_GRD = 7'b1000100;
  localparam logic [6:0] O_HT  = 7'b0100100;
  localparam logic [6:0] O_PR  = 7'b0010100;
  localparam logic [6:0] O_CG  = 7'b0001100;
  localparam logic [6:0] O_DN  = 7'b0000110;
  localparam logic [6:0] O_FT  = 7'b0000101;

  typedef struct {
    logic       vend, chg, cup, water, hr, fclr;
    logic [2:0] st;
    logic [6:0] o;
  } vec_t;

  logic clk, reset;
  logic vend_req, change_req, cup_present, water_ok, heat_ready, fault_clr;
  logic grinder_on, heater_on, pump_on, change_out, busy, done, fault;
  logic [2:0] state;

  int vectors;
  int miscompares;
  vec_t tbl[$];

  coffee_brew_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .vend_req   (vend_req),
    .change_req (change_req),
    .cup_present(cup_present),
    .water_ok   (water_ok),
    .heat_ready (heat_ready),
    .fault_clr  (fault_clr),
    .grinder_on (grinder_on),
    .heater_on  (heater_on),
    .pump_on    (pump_on),
    .change_out (change_out),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .state      (state)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [2:0] exp_st, input logic [6:0] exp_o);
    logic [9:0] got, exp;
    got = {state, grinder_on, heater_on, pump_on, change_out, busy, done, fault};
    exp = {exp_st, exp_o};
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
               nm, got[9:7], got[6:0], exp[9:7], exp[6:0]);
    end
  endtask

  task automatic drive(input logic v, c, cp, w, h, f);
    vend_req    = v;
    change_req  = c;
    cup_present = cp;
    water_ok    = w;
    heat_ready  = h;
    fault_clr   = f;
  endtask

  // Apply inputs for one cycle and check the outputs just after the edge.
  task automatic cyc(input string nm, input logic v, c, cp, w, h, f,
                     input logic [2:0] exp_st, input logic [6:0] exp_o);
    drive(v, c, cp, w, h, f);
    @(posedge clk);
    #1;
    check(nm, exp_st, exp_o);
  endtask

  task automatic add(input logic v, c, cp, w, h, f, input logic [2:0] st, input logic [6:0] o);
    vec_t e;
    e.vend = v; e.chg = c; e.cup = cp; e.water = w; e.hr = h; e.fclr = f;
    e.st = st; e.o = o;
    tbl.push_back(e);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    check("reset_state", 3'd0, O_IDL);

    // Nominal brew with change owed; vend during GRIND and DONE is ignored.
    add(1,1,1,1,0,0, 3'd1, O_CHK);
    add(0,0,1,1,0,0, 3'd2, O_GRD);
    add(1,0,1,1,0,0, 3'd2, O_GRD);
    add(0,0,1,1,0,0, 3'd2, O_GRD);
    add(0,0,1,1,0,0, 3'd2, O_GRD);
    add(0,0,1,1,0,0, 3'd3, O_HT);
    add(0,0,1,1,0,0, 3'd3, O_HT);
    add(0,0,1,1,0,0, 3'd3, O_HT);
    add(0,0,1,1,1,0, 3'd4, O_PR);
    for (int i = 0; i < 5; i++) add(0,0,1,1,0,0, 3'd4, O_PR);
    add(0,0,1,1,0,0, 3'd5, O_CG);
    add(0,0,1,1,0,0, 3'd6, O_DN);
    add(1,0,1,1,0,0, 3'd0, O_IDL);
    add(0,0,1,1,0,0, 3'd0, O_IDL);
    // Pre-check fault with change owed; fault holds until cleared.
    add(1,1,1,0,0,0, 3'd1, O_CHK);
    add(1,0,1,0,0,0, 3'd7, O_FT);
    add(1,0,1,1,0,0, 3'd7, O_FT);
    add(0,0,1,1,0,1, 3'd0, O_IDL);
    add(0,0,1,1,0,0, 3'd0, O_IDL);
    // Nominal brew without change; the cleared fault left no change pending.
    add(1,0,1,1,0,0, 3'd1, O_CHK);
    for (int i = 0; i < 4; i++) add(0,0,1,1,0,0, 3'd2, O_GRD);
    add(0,0,1,1,0,0, 3'd3, O_HT);
    add(0,0,1,1,0,0, 3'd3, O_HT);
    add(0,0,1,1,0,0, 3'd3, O_HT);
    add(0,0,1,1,1,0, 3'd4, O_PR);
    for (int i = 0; i < 5; i++) add(0,0,1,1,0,0, 3'd4, O_PR);
    add(0,0,1,1,0,0, 3'd6, O_DN);
    add(0,0,1,1,0,0, 3'd0, O_IDL);

    // Hold reset across a clock edge, then release away from the edge.
    @(posedge clk);
    #1;
    check("reset_held", 3'd0, O_IDL);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_release", 3'd0, O_IDL);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].vend, tbl[i].chg, tbl[i].cup,
          tbl[i].water, tbl[i].hr, tbl[i].fclr, tbl[i].st, tbl[i].o);
    end

    // Heat timeout: exactly 10 HEAT cycles, then FAULT with heater off.
    cyc("to_check", 1,0,1,1,0,0, 3'd1, O_CHK);
    for (int i = 0; i < 4; i++) cyc($sformatf("to_grind%0d", i), 0,0,1,1,0,0, 3'd2, O_GRD);
    for (int i = 0; i < 10; i++) cyc($sformatf("to_heat%0d", i), 0,0,1,1,0,0, 3'd3, O_HT);
    cyc("to_fault", 0,0,1,1,0,0, 3'd7, O_FT);
    cyc("to_clear", 0,0,1,1,0,1, 3'd0, O_IDL);

    // Cup removed in the third pour cycle.
    cyc("cup_check", 1,0,1,1,0,0, 3'd1, O_CHK);
    for (int i = 0; i < 4; i++) cyc($sformatf("cup_grind%0d", i), 0,0,1,1,0,0, 3'd2, O_GRD);
    cyc("cup_heat", 0,0,1,1,0,0, 3'd3, O_HT);
    cyc("cup_pour1", 0,0,1,1,1,0, 3'd4, O_PR);
    cyc("cup_pour2", 0,0,1,1,0,0, 3'd4, O_PR);
    cyc("cup_pour3", 0,0,1,1,0,0, 3'd4, O_PR);
    cyc("cup_fault", 0,0,0,1,0,0, 3'd7, O_FT);
    cyc("cup_clear", 0,0,1,1,0,1, 3'd0, O_IDL);

    // Asynchronous reset mid-pour drops the pump without a clock edge.
    cyc("rst_check", 1,1,1,1,0,0, 3'd1, O_CHK);
    for (int i = 0; i < 4; i++) cyc($sformatf("rst_grind%0d", i), 0,0,1,1,0,0, 3'd2, O_GRD);
    cyc("rst_heat", 0,0,1,1,0,0, 3'd3, O_HT);
    cyc("rst_pour1", 0,0,1,1,1,0, 3'd4, O_PR);
    cyc("rst_pour2", 0,0,1,1,0,0, 3'd4, O_PR);
    #2;
    reset = 1'b0;
    #1;
    check("rst_async", 3'd0, O_IDL);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int i = 0; i < 8; i++) cyc($sformatf("rst_idle%0d", i), 0,0,1,1,1,0, 3'd0, O_IDL);
    cyc("rst_rebrew", 1,0,1,1,0,0, 3'd1, O_CHK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
